// File: rtl/puf_pkg.sv
// Shared types for the PUF challenge sequencer: FSM state encoding and seed lock-up guard.
// Latency: n/a (package).
// Backpressure: n/a (package).
package puf_pkg;

    localparam int DEF_NUM_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT,
        STEP,
        DONE
    } seq_state_t;

    // An XNOR LFSR never leaves all-ones, so that seed is remapped to all-zeros.
    function automatic logic [31:0] lockup_fix(input logic [31:0] seed, input int unsigned width);
        logic [31:0] mask;
        mask = (width >= 32) ? 32'hFFFF_FFFF : ((32'h1 << width) - 32'h1);
        return ((seed & mask) == mask) ? 32'h0 : (seed & mask);
    endfunction

endpackage

// File: rtl/puf_challenge_sequencer_if.sv
// Sequencer <-> datapath bundle: LFSR control/readback and RO comparison start/done handshake.
// Latency: wires only.
// Backpressure: meas_start/meas_done handshake; datapath paces the sequencer via meas_done.
interface puf_challenge_sequencer_if
    import puf_pkg::*;
#(
    parameter int NUM_BITS = DEF_NUM_BITS
);
    logic [NUM_BITS-1:0] lfsr_data;
    logic                lfsr_en;
    logic                lfsr_seed_dv;
    logic [NUM_BITS-1:0] lfsr_seed;
    logic [NUM_BITS-1:0] challenge;
    logic                meas_start;
    logic                meas_done;
    logic                meas_bit;

    modport master (
        input  lfsr_data, meas_done, meas_bit,
        output lfsr_en, lfsr_seed_dv, lfsr_seed, challenge, meas_start
    );

    modport slave (
        output lfsr_data, meas_done, meas_bit,
        input  lfsr_en, lfsr_seed_dv, lfsr_seed, challenge, meas_start
    );
endinterface

// File: rtl/puf_resp_accum.sv
// Response shift register with bit counter; last flags the final bit of the run.
// Latency: 1 cycle from shift_en to updated response.
// Backpressure: none; shifts whenever shift_en is high.
module puf_resp_accum #(
    parameter int RESP_BITS = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clear,
    input  logic                 shift_en,
    input  logic                 bit_in,
    output logic [RESP_BITS-1:0] response,
    output logic                 last
);
    localparam int CW = $clog2(RESP_BITS);

    logic [CW-1:0] bit_cnt;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            response <= '0;
            bit_cnt  <= '0;
        end else if (shift_en) begin
            response <= {response[RESP_BITS-2:0], bit_in};
            bit_cnt  <= bit_cnt + 1'b1;
        end
    end

    assign last = (bit_cnt == CW'(RESP_BITS - 1));

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Runs one RO-PUF challenge/response pass: seed LFSR, issue challenges, collect RESP_BITS bits.
// Latency: first meas_start 2 cycles after start; 2+d cycles per bit; done 1 cycle after last bit.
// Backpressure: waits on meas_done per bit, aborts with sticky error after TIMEOUT WAIT cycles.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int NUM_BITS  = DEF_NUM_BITS,
    parameter int RESP_BITS = 32,
    parameter int TIMEOUT   = 4096
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      start,
    input  logic [NUM_BITS-1:0]       seed_in,
    puf_challenge_sequencer_if.master dp,
    output logic                      busy,
    output logic                      done,
    output logic                      error,
    output logic [RESP_BITS-1:0]      response
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
    localparam logic [TW-1:0] TO_SAT  = TW'(TIMEOUT);

    seq_state_t          state;
    seq_state_t          state_nxt;
    logic [NUM_BITS-1:0] seed_q;
    logic [NUM_BITS-1:0] challenge_q;
    logic [TW-1:0]       tcnt;
    logic                error_q;
    logic                acc_clear;
    logic                shift_en;
    logic                last_bit;
    logic                lfsr_en;
    logic                lfsr_seed_dv;
    logic                meas_start;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            seed_q      <= '0;
            challenge_q <= '0;
            tcnt        <= '0;
            error_q     <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && start) begin
                seed_q  <= NUM_BITS'(lockup_fix(32'(seed_in), NUM_BITS));
                error_q <= 1'b0;
            end
            if (state == ISSUE) begin
                challenge_q <= dp.lfsr_data;
                tcnt        <= '0;
            end
            // A meas_done arriving on the expiry cycle still counts as a valid bit.
            if (state == WAIT && !dp.meas_done) begin
                if (tcnt == TO_LAST) begin
                    error_q <= 1'b1;
                end else if (tcnt != TO_SAT) begin
                    tcnt <= tcnt + 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_nxt    = state;
        lfsr_en      = 1'b0;
        lfsr_seed_dv = 1'b0;
        meas_start   = 1'b0;
        done         = 1'b0;
        acc_clear    = 1'b0;
        shift_en     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    acc_clear = 1'b1;
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                lfsr_en      = 1'b1;
                lfsr_seed_dv = 1'b1;
                state_nxt    = ISSUE;
            end
            ISSUE: begin
                meas_start = 1'b1;
                state_nxt  = WAIT;
            end
            WAIT: begin
                if (dp.meas_done) begin
                    shift_en  = 1'b1;
                    state_nxt = last_bit ? DONE : STEP;
                end else if (tcnt == TO_LAST) begin
                    state_nxt = IDLE;
                end
            end
            STEP: begin
                lfsr_en   = 1'b1;
                state_nxt = ISSUE;
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    puf_resp_accum #(
        .RESP_BITS (RESP_BITS)
    ) u_accum (
        .clk      (clk),
        .rst      (rst),
        .clear    (acc_clear),
        .shift_en (shift_en),
        .bit_in   (dp.meas_bit),
        .response (response),
        .last     (last_bit)
    );

    assign busy            = (state != IDLE);
    assign error           = error_q;
    assign dp.lfsr_en      = lfsr_en;
    assign dp.lfsr_seed_dv = lfsr_seed_dv;
    assign dp.lfsr_seed    = seed_q;
    assign dp.challenge    = challenge_q;
    assign dp.meas_start   = meas_start;

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed bench: 8-bit XNOR LFSR model plus a delayed responder around puf_challenge_sequencer.
module tb_puf_challenge_sequencer;

    logic       clk;
    logic       rst;
    logic       start;
    logic [7:0] seed_in;
    logic       busy;
    logic       done;
    logic       error;
    logic [7:0] response;

    logic [7:0] lfsr_q;
    logic       rsp_done;
    logic       rsp_bit;
    logic       noise_done;
    logic       noise_bit;

    int         tests = 0;
    int         fails = 0;

    bit         rsp_en    = 1'b1;
    int         rsp_delay = 3;
    int         rsp_limit = 99;
    int         rsp_cnt   = 0;
    logic [7:0] rsp_bits  = 8'hB2;
    logic [7:0] chal_log [8];

    puf_challenge_sequencer_if #(.NUM_BITS(8)) bus ();

    assign bus.lfsr_data = lfsr_q;
    assign bus.meas_done = rsp_done | noise_done;
    assign bus.meas_bit  = rsp_bit | noise_bit;

    puf_challenge_sequencer #(
        .NUM_BITS  (8),
        .RESP_BITS (8),
        .TIMEOUT   (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .seed_in  (seed_in),
        .dp       (bus),
        .busy     (busy),
        .done     (done),
        .error    (error),
        .response (response)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [7:0] lfsr_next(input logic [7:0] q);
        return {q[6:0], ~(q[7] ^ q[5] ^ q[4] ^ q[3])};
    endfunction

    // LFSR model: control sampled mid-cycle, state updated just after the edge.
    initial begin
        logic       en_s;
        logic       dv_s;
        logic [7:0] sd_s;
        lfsr_q = 8'h00;
        forever begin
            @(negedge clk);
            en_s = bus.lfsr_en;
            dv_s = bus.lfsr_seed_dv;
            sd_s = bus.lfsr_seed;
            @(posedge clk);
            #1;
            if (en_s) lfsr_q = dv_s ? sd_s : lfsr_next(lfsr_q);
        end
    end

    // Responder: meas_done pulses rsp_delay cycles after each meas_start, MSB-first bits.
    initial begin
        rsp_done = 1'b0;
        rsp_bit  = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (rsp_en && bus.meas_start && rsp_cnt < rsp_limit && rsp_cnt < 8) begin
                repeat (rsp_delay) @(posedge clk);
                #1;
                rsp_done = 1'b1;
                rsp_bit  = rsp_bits[3'(7 - rsp_cnt)];
                chal_log[rsp_cnt[2:0]] = bus.challenge;
                rsp_cnt++;
                @(posedge clk);
                #1;
                rsp_done = 1'b0;
                rsp_bit  = 1'b0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Called just after a posedge; start is high for cycle 0 of the run.
    task automatic run_start(input logic [7:0] seed);
        rsp_cnt = 0;
        for (int k = 0; k < 8; k++) chal_log[k] = 8'hxx;
        seed_in = seed;
        start   = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    // Samples cycles first.. until the FSM is back in IDLE; optional ISSUE/STEP noise.
    task automatic wait_done(input int first, input bit noisy, output int cyc, output int ndone);
        bit noise;
        cyc   = 0;
        ndone = 0;
        for (int i = first; i <= 200; i++) begin
            @(negedge clk);
            if (done) begin
                ndone++;
                if (cyc == 0) cyc = i;
            end
            if (i > first && !busy) break;
            noise      = noisy && (bus.meas_start || (bus.lfsr_en && !bus.lfsr_seed_dv));
            noise_done = noise;
            noise_bit  = noise;
            start      = noise;
        end
        noise_done = 1'b0;
        noise_bit  = 1'b0;
        start      = 1'b0;
        check("post_done_low", {31'd0, done}, 32'd0);
    endtask

    task automatic verify_run(input string tag, input logic [7:0] seed_eff, input logic [7:0] exp_resp,
                              input int cyc, input int ndone);
        logic [7:0] exp_c;
        check({tag, "_done_cycle"}, cyc, 41);
        check({tag, "_done_count"}, ndone, 1);
        check({tag, "_response"}, {24'd0, response}, {24'd0, exp_resp});
        exp_c = seed_eff;
        for (int k = 0; k < 8; k++) begin
            check($sformatf("%s_chal%0d", tag, k), {24'd0, chal_log[k]}, {24'd0, exp_c});
            exp_c = lfsr_next(exp_c);
        end
    endtask

    initial begin
        int cyc;
        int ndone;
        int nstart;
        int nd;

        rst        = 1'b1;
        start      = 1'b0;
        seed_in    = 8'h00;
        noise_done = 1'b0;
        noise_bit  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_flags", {29'd0, done, error, bus.meas_start}, 32'd0);
        check("rst_lfsr_ctl", {30'd0, bus.lfsr_en, bus.lfsr_seed_dv}, 32'd0);
        check("rst_regs", {8'd0, response, bus.challenge, bus.lfsr_seed}, 32'd0);

        // Nominal run: seed 5A, bits 1,0,1,1,0,0,1,0.
        @(posedge clk);
        #1;
        run_start(8'h5A);
        @(negedge clk);
        check("load_ctl", {30'd0, bus.lfsr_en, bus.lfsr_seed_dv}, 32'd3);
        check("load_seed", {24'd0, bus.lfsr_seed}, 32'h5A);
        @(negedge clk);
        check("issue_meas_start", {31'd0, bus.meas_start}, 32'd1);
        wait_done(3, 1'b0, cyc, ndone);
        verify_run("run5a", 8'h5A, 8'hB2, cyc, ndone);
        check("run5a_chal1_hand", {24'd0, chal_log[1]}, 32'hB5);
        check("run5a_chal2_hand", {24'd0, chal_log[2]}, 32'h6A);

        // All-ones seed is remapped to all-zeros.
        rsp_bits = 8'hFF;
        @(posedge clk);
        #1;
        run_start(8'hFF);
        @(negedge clk);
        check("ff_load_seed", {24'd0, bus.lfsr_seed}, 32'h00);
        wait_done(2, 1'b0, cyc, ndone);
        verify_run("runff", 8'h00, 8'hFF, cyc, ndone);

        // Timeout: responder answers three bits then goes silent.
        rsp_bits  = 8'hA0;
        rsp_limit = 3;
        @(posedge clk);
        #1;
        run_start(8'h5A);
        nstart = 0;
        nd     = 0;
        for (int i = 1; i <= 100 && nstart < 4; i++) begin
            @(negedge clk);
            if (bus.meas_start) nstart++;
            if (done) nd++;
        end
        check("to_issue4_seen", nstart, 4);
        repeat (16) begin
            @(negedge clk);
            if (done) nd++;
        end
        check("to_wait16_busy", {30'd0, busy, error}, 32'd2);
        @(negedge clk);
        if (done) nd++;
        check("to_expired", {30'd0, busy, error}, 32'd1);
        check("to_no_done", nd, 0);
        check("to_partial_resp", {24'd0, response}, 32'h05);

        // Next start clears error and runs normally.
        rsp_bits  = 8'hB2;
        rsp_limit = 99;
        @(posedge clk);
        #1;
        run_start(8'h5A);
        @(negedge clk);
        check("rerun_err_clr", {31'd0, error}, 32'd0);
        check("rerun_resp_clr", {24'd0, response}, 32'h00);
        wait_done(2, 1'b0, cyc, ndone);
        verify_run("rerun", 8'h5A, 8'hB2, cyc, ndone);

        // start and meas_done injected in ISSUE/STEP must be ignored.
        @(posedge clk);
        #1;
        run_start(8'h5A);
        wait_done(1, 1'b1, cyc, ndone);
        verify_run("noise", 8'h5A, 8'hB2, cyc, ndone);

        // Reset in WAIT of bit 4.
        @(posedge clk);
        #1;
        run_start(8'h5A);
        nstart = 0;
        for (int i = 1; i <= 100 && nstart < 5; i++) begin
            @(negedge clk);
            if (bus.meas_start) nstart++;
        end
        check("rst_issue5_seen", nstart, 5);
        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("midrst_busy", {31'd0, busy}, 32'd0);
        check("midrst_flags", {26'd0, done, error, bus.meas_start, bus.lfsr_en, bus.lfsr_seed_dv, 1'b0}, 32'd0);
        check("midrst_regs", {8'd0, response, bus.challenge, bus.lfsr_seed}, 32'd0);
        repeat (6) @(posedge clk);
        #1;
        run_start(8'h5A);
        wait_done(1, 1'b0, cyc, ndone);
        verify_run("afterrst", 8'h5A, 8'hB2, cyc, ndone);

        // meas_done held as a 5-cycle level spans two WAIT entries: two bits only.
        rsp_en = 1'b0;
        @(posedge clk);
        #1;
        run_start(8'h5A);
        nstart = 0;
        for (int i = 1; i <= 20 && nstart < 1; i++) begin
            @(negedge clk);
            if (bus.meas_start) nstart++;
        end
        @(posedge clk);
        #1;
        noise_done = 1'b1;
        noise_bit  = 1'b1;
        repeat (5) @(posedge clk);
        #1;
        noise_done = 1'b0;
        noise_bit  = 1'b0;
        @(negedge clk);
        check("level_resp", {24'd0, response}, 32'h03);
        check("level_busy", {31'd0, busy}, 32'd1);
        check("level_issue", {31'd0, bus.meas_start}, 32'd1);

        @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst    = 1'b0;
        rsp_en = 1'b1;
        @(negedge clk);
        check("final_idle", {31'd0, busy}, 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
